hamming_unpack: RTL and testbench

SECDED decoder for codewords produced by the team's Hamming packer/encoder. It accepts one CODED_WIDTH-bit extended-Hamming codeword per handshake and recomputes the syndrome and overall parity. It then corrects any single-bit error, flags double and invalid errors, and strips the parity positions to return DATA_WIDTH data bits. It sits on the receive side of protected links and RAMs as a two-stage valid/ready pipeline, and keeps saturating error counters for status reporting.

---
 rtl/hamming_unpack.sv | 204 ++++++++++++++++++++
 tb/tb_hamming_unpack.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_unpack.sv
`default_nettype none
// ============================================================================
// Module   : hamming_unpack
// Purpose  : SECDED (extended Hamming) decoder with a two-stage valid/ready
//            pipeline and saturating error counters.
//            Stage 1 registers the codeword, its syndrome and overall parity.
//            Stage 2 classifies, corrects single-bit errors, strips parity
//            positions and presents the decoded payload.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           in   1            clock, rising edge
//   rst_i           in   1            asynchronous active-high reset
//   in_valid_i      in   1            codeword valid
//   in_ready_o      out  1            codeword accepted this cycle
//   code_i          in   CODED_WIDTH  bit 0 overall parity, bits 2^i parity
//   out_valid_o     out  1            decoded word valid
//   out_ready_i     in   1            downstream accepts
//   data_o          out  DATA_WIDTH   decoded (corrected when possible) data
//   corrected_o     out  1            single-bit error corrected
//   uncorrectable_o out  1            double error or out-of-range syndrome
//   clr_counts_i    in   1            synchronous clear of both counters
//   corr_count_o    out  16           saturating corrected-word count
//   uncorr_count_o  out  16           saturating uncorrectable-word count
// ============================================================================
module hamming_unpack #(
  parameter  int DATA_WIDTH  = 32,
  // Smallest p with 2^p >= DATA_WIDTH + p + 1. With x = clog2(D+1) the answer
  // is always x or x+1, and clog2(D + x + 1) selects between them.
  localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CODED_WIDTH-1:0] code_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   corrected_o,
  output logic                   uncorrectable_o,
  input  logic                   clr_counts_i,
  output logic [15:0]            corr_count_o,
  output logic [15:0]            uncorr_count_o
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Codeword position of data bit k: the k-th index >= 3 that is not a power
  // of two.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int j = 3; j < CODED_WIDTH; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (cnt == k) pos = j;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Stage 1 state
  logic                   s1_valid_q, s1_valid_d;
  logic [CODED_WIDTH-1:0] s1_code_q,  s1_code_d;
  logic [ADDR_WIDTH-1:0]  s1_syn_q,   s1_syn_d;
  logic                   s1_par_q,   s1_par_d;
  // Stage 2 state
  logic                   s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]  data_q,     data_d;
  logic                   corr_q,     corr_d;
  logic                   uncorr_q,   uncorr_d;
  // Counters
  logic [15:0]            corr_cnt_q,   corr_cnt_d;
  logic [15:0]            uncorr_cnt_q, uncorr_cnt_d;

  logic                   s1_advance;
  logic                   s2_advance;
  logic                   out_fire;
  logic [ADDR_WIDTH-1:0]  syn_calc;
  logic                   par_calc;
  logic                   syn_in_range;
  logic                   is_corr;
  logic                   is_uncorr;
  logic [CODED_WIDTH-1:0] fixed_code;
  logic [DATA_WIDTH-1:0]  extract;

  // Stage 2 frees up when empty or when its word leaves; stage 1 then follows.
  assign s2_advance = !s2_valid_q || out_ready_i;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign in_ready_o = s1_advance;
  assign out_fire   = s2_valid_q && out_ready_i;

  // Syndrome bit i covers every codeword index with bit i set.
  always_comb begin
    syn_calc = '0;
    for (int j = 1; j < CODED_WIDTH; j++) begin
      for (int i = 0; i < ADDR_WIDTH; i++) begin
        if (((j >> i) & 1) == 1) syn_calc[i] = syn_calc[i] ^ code_i[j];
      end
    end
    par_calc = ^code_i;
  end

  // Classification. Odd parity with an in-range syndrome is a single error;
  // syndrome 0 in that case means the overall parity bit itself flipped.
  always_comb begin
    syn_in_range = (32'(s1_syn_q) < CODED_WIDTH);
    is_corr      = s1_par_q && syn_in_range;
    is_uncorr    = (s1_par_q && !syn_in_range) || (!s1_par_q && (s1_syn_q != '0));
    fixed_code   = s1_code_q;
    for (int j = 0; j < CODED_WIDTH; j++) begin
      if (is_corr && (s1_syn_q == ADDR_WIDTH'(j))) fixed_code[j] = ~fixed_code[j];
    end
  end

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_extract
    localparam int POS = data_pos(k);
    assign extract[k] = fixed_code[POS];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (s1_advance) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_code_d = code_i;
        s1_syn_d  = syn_calc;
        s1_par_d  = par_calc;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d   = extract;
        corr_d   = is_corr;
        uncorr_d = is_uncorr;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (clr_counts_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (out_fire && corr_q && (corr_cnt_q != CNT_MAX))
        corr_cnt_d = corr_cnt_q + 16'd1;
      if (out_fire && uncorr_q && (uncorr_cnt_q != CNT_MAX))
        uncorr_cnt_d = uncorr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      data_q       <= '0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s2_valid_q   <= s2_valid_d;
      data_q       <= data_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid_o     = s2_valid_q;
  assign data_o          = data_q;
  assign corrected_o     = corr_q;
  assign uncorrectable_o = uncorr_q;
  assign corr_count_o    = corr_cnt_q;
  assign uncorr_count_o  = uncorr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_unpack
// Purpose  : Directed self-checking bench for hamming_unpack (DATA_WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_unpack;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [38:0] code_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] data_o;
  logic        corrected_o;
  logic        uncorrectable_o;
  logic        clr_counts_i;
  logic [15:0] corr_count_o;
  logic [15:0] uncorr_count_o;

  always #5 clk_i = ~clk_i;

  hamming_unpack #(.DATA_WIDTH(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .code_i          (code_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .data_o          (data_o),
    .corrected_o     (corrected_o),
    .uncorrectable_o (uncorrectable_o),
    .clr_counts_i    (clr_counts_i),
    .corr_count_o    (corr_count_o),
    .uncorr_count_o  (uncorr_count_o)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [15:0] exp_c    = '0;
  logic [15:0] exp_u    = '0;

  // Backpressure stream: mix of clean, corrected and uncorrectable words.
  logic [38:0] scode [8];
  logic [31:0] sdata [8];
  logic        scorr [8];
  logic        sunc  [8];
  int          sent, recv, occ, cyc;
  logic        stalled, acc, deliver;
  logic [31:0] hold_d;
  logic        hold_c, hold_u;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic bump(input logic ec, input logic eu);
    if (ec && exp_c != 16'hFFFF) exp_c = exp_c + 16'd1;
    if (eu && exp_u != 16'hFFFF) exp_u = exp_u + 16'd1;
  endtask

  // Called just after a falling edge. One word, no stall, 2-cycle latency.
  task automatic send_one(input string tag, input logic [38:0] code, input logic [31:0] ed,
                          input logic ec, input logic eu, input logic clr_at_out);
    in_valid_i  = 1'b1;
    code_i      = code;
    out_ready_i = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready_o), 64'(1'b1));
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(out_valid_o), 64'(1'b0));
    @(negedge clk_i);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'(1'b1));
    chk({tag, "_data"}, 64'(data_o), 64'(ed));
    chk({tag, "_corr"}, 64'(corrected_o), 64'(ec));
    chk({tag, "_unc"}, 64'(uncorrectable_o), 64'(eu));
    clr_counts_i = clr_at_out;
    if (clr_at_out) begin
      exp_c = '0;
      exp_u = '0;
    end else begin
      bump(ec, eu);
    end
    @(negedge clk_i);
    clr_counts_i = 1'b0;
    chk({tag, "_drained"}, 64'(out_valid_o), 64'(1'b0));
    chk({tag, "_corr_cnt"}, 64'(corr_count_o), 64'(exp_c));
    chk({tag, "_unc_cnt"}, 64'(uncorr_count_o), 64'(exp_u));
  endtask

  initial begin
    scode[0] = 39'h0;          sdata[0] = 32'h0; scorr[0] = 1'b0; sunc[0] = 1'b0;
    scode[1] = 39'hF;          sdata[1] = 32'h1; scorr[1] = 1'b0; sunc[1] = 1'b0;
    scode[2] = 39'h33;         sdata[2] = 32'h2; scorr[2] = 1'b0; sunc[2] = 1'b0;
    scode[3] = 39'h55;         sdata[3] = 32'h4; scorr[3] = 1'b0; sunc[3] = 1'b0;
    scode[4] = 39'h96;         sdata[4] = 32'h8; scorr[4] = 1'b0; sunc[4] = 1'b0;
    scode[5] = 39'h20F;        sdata[5] = 32'h1; scorr[5] = 1'b1; sunc[5] = 1'b0;
    scode[6] = 39'h28;         sdata[6] = 32'h3; scorr[6] = 1'b0; sunc[6] = 1'b1;
    scode[7] = 39'h10000_0081; sdata[7] = 32'h8; scorr[7] = 1'b0; sunc[7] = 1'b1;

    rst_i        = 1'b1;
    in_valid_i   = 1'b0;
    out_ready_i  = 1'b0;
    clr_counts_i = 1'b0;
    code_i       = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 64'(out_valid_o), 64'(1'b0));
    chk("rst_data", 64'(data_o), 64'(32'h0));
    chk("rst_corr", 64'(corrected_o), 64'(1'b0));
    chk("rst_unc", 64'(uncorrectable_o), 64'(1'b0));
    chk("rst_corr_cnt", 64'(corr_count_o), 64'(16'h0));
    chk("rst_unc_cnt", 64'(uncorr_count_o), 64'(16'h0));
    rst_i = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'(1'b1));
    @(negedge clk_i);

    // Directed decodes
    send_one("clean0", 39'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    send_one("clean1", 39'hF, 32'h1, 1'b0, 1'b0, 1'b0);
    send_one("single5", 39'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    send_one("single0", 39'h1, 32'h0, 1'b1, 1'b0, 1'b0);
    // Bits 3 and 5 carry data bits 0 and 1; raw extract is 0x3.
    send_one("double", 39'h28, 32'h3, 1'b0, 1'b1, 1'b0);
    // Syndrome 39 is out of range: bit 7 (data bit 3) stays set.
    send_one("invalid", 39'h10000_0081, 32'h8, 1'b0, 1'b1, 1'b0);

    // Backpressure: out_ready pattern 1,0,0 repeating, input always offered.
    sent = 0; recv = 0; occ = 0; cyc = 0; stalled = 1'b0;
    hold_d = '0; hold_c = 1'b0; hold_u = 1'b0;
    while ((recv < 8) && (cyc < 100)) begin
      out_ready_i = ((cyc % 3) == 0);
      in_valid_i  = (sent < 8);
      code_i      = (sent < 8) ? scode[sent] : 39'h0;
      #1;
      chk("bp_in_ready", 64'(in_ready_o), 64'(!((occ == 2) && !out_ready_i)));
      if (stalled) begin
        chk("bp_hold_valid", 64'(out_valid_o), 64'(1'b1));
        chk("bp_hold_data", 64'(data_o), 64'(hold_d));
        chk("bp_hold_corr", 64'(corrected_o), 64'(hold_c));
        chk("bp_hold_unc", 64'(uncorrectable_o), 64'(hold_u));
      end
      deliver = out_valid_o && out_ready_i;
      if (deliver) begin
        chk("bp_data", 64'(data_o), 64'(sdata[recv]));
        chk("bp_corr", 64'(corrected_o), 64'(scorr[recv]));
        chk("bp_unc", 64'(uncorrectable_o), 64'(sunc[recv]));
        bump(scorr[recv], sunc[recv]);
        recv++;
      end
      stalled = out_valid_o && !out_ready_i;
      hold_d  = data_o;
      hold_c  = corrected_o;
      hold_u  = uncorrectable_o;
      acc     = in_valid_i && in_ready_o;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(deliver);
      @(negedge clk_i);
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("bp_recv_count", 64'(recv), 64'(8));
    chk("bp_corr_cnt", 64'(corr_count_o), 64'(exp_c));
    chk("bp_unc_cnt", 64'(uncorr_count_o), 64'(exp_u));

    // Counter clear
    out_ready_i  = 1'b1;
    clr_counts_i = 1'b1;
    @(negedge clk_i);
    clr_counts_i = 1'b0;
    exp_c = '0;
    exp_u = '0;
    chk("clr_corr_cnt", 64'(corr_count_o), 64'(16'h0));
    chk("clr_unc_cnt", 64'(uncorr_count_o), 64'(16'h0));

    // Saturation: 65534 corrected words at full rate, then 3 more.
    in_valid_i = 1'b1;
    code_i     = 39'h20;
    repeat (65534) @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    exp_c = 16'hFFFE;
    chk("preload_corr_cnt", 64'(corr_count_o), 64'(16'hFFFE));
    send_one("sat1", 39'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    send_one("sat2", 39'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    send_one("sat3", 39'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("sat_corr_cnt", 64'(corr_count_o), 64'(16'hFFFF));

    // Clear in the same cycle as a counted handshake: increment is lost.
    send_one("clr_race", 39'h28, 32'h3, 1'b0, 1'b1, 1'b1);

    // Reset with two words in flight.
    send_one("pre_rst", 39'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    code_i      = 39'h20F;
    @(negedge clk_i);
    code_i = 39'h28;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("full_valid", 64'(out_valid_o), 64'(1'b1));
    chk("full_data", 64'(data_o), 64'(32'h1));
    chk("full_in_ready", 64'(in_ready_o), 64'(1'b0));
    rst_i = 1'b1;
    #1;
    exp_c = '0;
    exp_u = '0;
    chk("arst_valid", 64'(out_valid_o), 64'(1'b0));
    chk("arst_data", 64'(data_o), 64'(32'h0));
    chk("arst_corr", 64'(corrected_o), 64'(1'b0));
    chk("arst_corr_cnt", 64'(corr_count_o), 64'(16'h0));
    chk("arst_unc_cnt", 64'(uncorr_count_o), 64'(16'h0));
    @(negedge clk_i);
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_valid1", 64'(out_valid_o), 64'(1'b0));
    @(negedge clk_i);
    chk("post_rst_valid2", 64'(out_valid_o), 64'(1'b0));
    send_one("post_rst", 39'hF, 32'h1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
